// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry, derived totals
// and sync polarity.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_CW       = 10;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Both sync outputs are asserted low.
  localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/rise_tick.sv
// Rising-edge detector: samples a slow square wave that is synchronous to
// clk and emits a registered one-clk pulse on each rising edge.
module rise_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic tick
);

  logic s;

  // Keep the previous sample and flag a 0->1 transition one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= 1'b0;
      tick <= 1'b0;
    end else begin
      s    <= sig_in;
      tick <= sig_in & ~s;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator running on the system clock. The 25 MHz divider
// output is treated as data and turned into a pixel tick; h/v counters and
// the registered sync/video decode advance only on that tick.
// Optional: define VGA_FRAME_CNT_EN to add an 8-bit frame counter output.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          clk_25,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_tick,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int unsigned LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(FRAME_LINES - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  if ((2 ** CW) < LINE_LEN || (2 ** CW) < FRAME_LINES) begin : g_cw_check
    $error("vga_sync_gen: CW too narrow for the configured timing");
  end

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          frame_wrap;

  rise_tick u_tick (
    .clk    (clk_in),
    .rst_n  (rst_n),
    .sig_in (clk_25),
    .tick   (pix_tick)
  );

  assign pix_x = h_cnt;
  assign pix_y = v_cnt;

  // Next counter position if this cycle carries a pixel tick.
  always_comb begin
    h_next     = h_cnt + 1'b1;
    v_next     = v_cnt;
    frame_wrap = 1'b0;
    if (h_cnt == H_LAST) begin
      h_next = '0;
      if (v_cnt == V_LAST) begin
        v_next     = '0;
        frame_wrap = 1'b1;
      end else begin
        v_next = v_cnt + 1'b1;
      end
    end
  end

  // Counters plus decode taken from the next position, so every output moves
  // on the same edge as the counters; nothing changes without a tick, which
  // also keeps video_on low from reset until the first tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick & frame_wrap;
      if (pix_tick) begin
        h_cnt    <= h_next;
        v_cnt    <= v_next;
        hsync    <= (h_next >= HS_START && h_next < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync    <= (v_next >= VS_START && v_next < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on <= (h_next < H_VIS) && (v_next < V_VIS);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter steps on the same edge that raises frame_start.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_tick && frame_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the 25 MHz pixel-rate square wave from the clock divider and produces 640x480@60 VGA timing: hsync, vsync, active-video flag, and pixel coordinates.
- Runs entirely on the 100 MHz system clock.
- clk_25 is a data input that is edge-detected into a single-cycle pixel tick. It is never used as a clock.
- Drives the game renderer and the RGB output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CW, 10, coordinate/counter width

Ports:
- clk_in  input  1  100 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- clk_25  input  1  25 MHz square wave from the divider, synchronous to clk_in
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video_on  output  1  high while the current pixel is in the visible area
- pix_x  output  CW  current pixel column
- pix_y  output  CW  current pixel row
- pix_tick  output  1  one-clk_in pulse per pixel advance
- frame_start  output  1  one-clk_in pulse when the counters wrap to (0,0)

Behaviour:
- Reset (async assert, sync release):
  - internal clk_25 sample=0, h_cnt=0, v_cnt=0
  - pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=0, pix_tick=0, frame_start=0
- Tick generation:
  - Register s = clk_25 every clk_in.
  - Tick condition: clk_25==1 && s==0.
  - pix_tick is registered, so it rises one clk_in after clk_25 rises.
  - With a 4-cycle clk_25 period, pix_tick has exactly one pulse per 4 clk_in cycles.
- Counters advance only in a cycle where pix_tick==1:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - h_cnt==H_TOTAL-1 wraps to 0 and increments v_cnt. Otherwise h_cnt increments.
  - v_cnt==V_TOTAL-1 at an h wrap wraps to 0.
  - No other state.
- Output decode: registered, computed from next-state counters, so all outputs change on the same clk_in edge as the counters.
  - hsync=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - video_on=1 iff h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. It stays 0 after reset until the first pix_tick.
  - pix_x=h_cnt and pix_y=v_cnt always, including blanking.
- frame_start: high for exactly one clk_in, on the edge where (h_cnt,v_cnt) goes from (799,524) to (0,0). It is not asserted at reset release.
- clk_25 stuck high or low: no ticks; all outputs hold their values.
- Reset mid-frame: all state returns to reset values immediately. The first tick after release yields h_cnt=1; the first frame_start follows a full 420000-tick frame.
- Counter width: CW must hold H_TOTAL-1. Compile-time check: 2**CW >= H_TOTAL and 2**CW >= V_TOTAL.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt (8 bits), reset to 0.
  - Increments (mod 256) in the same cycle frame_start pulses. 255 wraps to 0.
  - Used by the game for animation timing.
- Undefined: the port and register do not exist; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants: 640/16/96/48 and 480/10/2/33
  - derived H_TOTAL=800 and V_TOTAL=525
  - sync polarity constant SYNC_ACTIVE=0
- One sub-module, rise_tick: samples clk_25 and emits the registered single-cycle pix_tick. It is reusable by other consumers of the divider outputs.
- The counters and decode stay in vga_sync_gen.

Test Plan:
- Reset check: hold rst_n=0 with clk_25 toggling -> hsync=1, vsync=1, video_on=0, pix_x=pix_y=0, no pix_tick.
- Tick check: release reset, drive clk_25 at clk_in/4 -> pix_tick one cycle after each clk_25 rise, period 4. After 640 ticks pix_x=640 and video_on falls on that same edge.
- Line timing: hsync falls exactly at pix_x=656 and rises at 752. After 800 ticks, pix_x=0 and pix_y=1.
- Frame timing: vsync low only for pix_y 490..491. frame_start pulses once at tick 420000 with pix_x=0, pix_y=0, and never at reset release.
- Stall: hold clk_25 high for 100 clk_in cycles mid-line at pix_x=300 -> no ticks and outputs frozen. Resume -> next tick gives pix_x=301.
- Reset mid-frame: assert rst_n=0 asynchronously at pix_y=200, pix_x=400 -> outputs return to reset values before the next clk_in edge. With VGA_FRAME_CNT_EN defined, frame_cnt reads 0 and reads 1 after the next full frame.
